// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter: start bit 1 cycle after the accepting edge if idle.
// Never stalls the producer beyond ready_in; pushes while full are dropped and flagged in sticky overflow.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 1024,
  parameter int DATA_BITS  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_BITS-1:0]             data_in,
  input  logic                             valid_in,
  output logic                             ready_in,
  output logic                             tx,
  output logic                             busy,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic [DATA_BITS-1:0]   shift_nxt;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   head;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   push;
  logic                   pop;
  logic                   baud_end;
  logic                   fifo_nempty;

  assign ready_in    = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push        = valid_in && ready_in;
  assign fifo_nempty = (fifo_count != '0);
  assign baud_end    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign pop         = fifo_nempty && ((state == IDLE) || (state == STOP && baud_end));
  assign head        = mem[rd_ptr];
  assign shift_nxt   = shift >> 1;
  assign busy        = (state != IDLE) || fifo_nempty;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (valid_in && !ready_in) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= head;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              shift   <= shift_nxt;
              tx      <= shift_nxt[0];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit so queued bytes go out with no idle gap.
            if (pop) begin
              shift <= head;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected bytes, a monitor decodes every tx frame bit-by-bit.
module tb_uart_tx_fifo;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       ready_in;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int frames_done = 0;
  int frames_started = 0;
  int max_count = 0;
  bit mon_flush = 1'b0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < target) chk("wait_frames", frames_done, target);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    valid_in = 1'b0;
    mon_flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: checks every sample of each frame against the queued byte.
  initial begin : monitor
    bit in_frame = 1'b0;
    bit have_exp = 1'b0;
    bit shape_ok = 1'b1;
    int idx = 0;
    logic [9:0] fb = '1;
    logic [7:0] got = '0;
    logic [7:0] want = '0;
    forever begin
      @(negedge clk);
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (mon_flush) begin
        in_frame = 1'b0;
        mon_flush = 1'b0;
      end else if (rst) begin
        if (!in_frame && tx == 1'b0) begin
          in_frame = 1'b1;
          idx = 0;
          shape_ok = 1'b1;
          got = '0;
          starts.push_back(cyc);
          frames_started++;
          chk("frame_expected", int'(exp_q.size() > 0), 1);
          have_exp = (exp_q.size() > 0);
          want = have_exp ? exp_q.pop_front() : 8'h00;
          fb = {1'b1, want, 1'b0};
        end
        if (in_frame) begin
          if (tx !== fb[idx / CPB]) shape_ok = 1'b0;
          if (idx % CPB == CPB / 2 && idx / CPB >= 1 && idx / CPB <= 8) got[idx / CPB - 1] = tx;
          idx++;
          if (idx == FRAME) begin
            in_frame = 1'b0;
            frames_done++;
            if (have_exp) begin
              chk("frame_byte", got, want);
              chk("frame_shape", shape_ok, 1);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d required < 40000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c;
    int fd0;
    int fs0;
    int s;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_ready_in", ready_in, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single 0xA5 while idle
    starts.delete();
    c = cyc;
    valid_in = 1'b1; data_in = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    valid_in = 1'b0;
    goto(c + 161);
    chk("t1_busy_in_stop", busy, 1);
    goto(c + 162);
    chk("t1_busy_after", busy, 0);
    chk("t1_count_after", fifo_count, 0);
    chk("t1_overflow", overflow, 0);
    wait_frames(1, 50);
    if (starts.size() > 0) chk("t1_start_cycle", starts[0], c + 2);

    // 2: four back-to-back bytes
    repeat (5) @(negedge clk);
    starts.delete();
    fd0 = frames_done;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      goto(c + i);
      valid_in = 1'b1; data_in = 8'(i); exp_q.push_back(8'(i));
    end
    @(negedge clk);
    valid_in = 1'b0;
    wait_frames(fd0 + 4, 4 * FRAME + 50);
    if (starts.size() == 4) begin
      chk("t2_first_start", starts[0], c + 2);
      for (int i = 1; i < 4; i++) chk("t2_no_gap", starts[i] - starts[i-1], FRAME);
    end else chk("t2_frames", starts.size(), 4);
    goto(c + 2 + 4 * FRAME);
    chk("t2_busy_after", busy, 0);

    // 3: six bytes into a depth-4 FIFO
    repeat (5) @(negedge clk);
    starts.delete();
    fd0 = frames_done;
    c = cyc;
    for (int i = 0; i < 6; i++) begin
      goto(c + i);
      if (i == 4) chk("t3_ready_before_5th", ready_in, 1);
      if (i == 5) begin
        chk("t3_ready_after_5th", ready_in, 0);
        chk("t3_count_full", fifo_count, 4);
      end
      valid_in = 1'b1; data_in = 8'h10 + 8'(i);
      if (i < 5) exp_q.push_back(8'h10 + 8'(i));
    end
    @(negedge clk);
    valid_in = 1'b0;
    chk("t3_overflow_set", overflow, 1);
    chk("t3_count_still_full", fifo_count, 4);
    wait_frames(fd0 + 5, 5 * FRAME + 50);
    if (starts.size() > 0) chk("t3_first_pop", starts[0], c + 2);
    chk("t3_overflow_sticky", overflow, 1);
    do_reset();
    chk("t3_overflow_cleared", overflow, 0);

    // 4: reset during data bit 3 of 0x5A with two bytes queued
    repeat (5) @(negedge clk);
    c = cyc;
    valid_in = 1'b1; data_in = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk); data_in = 8'h77;
    @(negedge clk); data_in = 8'h88;
    @(negedge clk); valid_in = 1'b0;
    s = c + 2;
    goto(s + 70);
    chk("t4_bit3_value", tx, 1);
    chk("t4_queued", fifo_count, 2);
    rst = 1'b0; mon_flush = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    chk("t4_tx", tx, 1);
    chk("t4_count", fifo_count, 0);
    chk("t4_ready", ready_in, 1);
    chk("t4_busy", busy, 0);
    fs0 = frames_started;
    goto(s + 71 + 400);
    chk("t4_no_more_frames", frames_started, fs0);

    // 5: forty bytes at one per frame period
    max_count = 0;
    fd0 = frames_done;
    c = cyc;
    for (int i = 0; i < 40; i++) begin
      goto(c + FRAME * i);
      valid_in = 1'b1; data_in = 8'(i * 37 + 5); exp_q.push_back(8'(i * 37 + 5));
      @(negedge clk);
      valid_in = 1'b0;
    end
    wait_frames(fd0 + 40, 2 * FRAME);
    chk("t5_max_count_le2", int'(max_count <= 2), 1);
    chk("t5_overflow", overflow, 0);
    chk("t5_queue_drained", exp_q.size(), 0);

    // 6: push while full in the same cycle as the STOP-end pop
    repeat (5) @(negedge clk);
    starts.delete();
    fd0 = frames_done;
    c = cyc;
    valid_in = 1'b1; data_in = 8'hC3; exp_q.push_back(8'hC3);
    @(negedge clk); valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      goto(c + 10 + i);
      valid_in = 1'b1; data_in = 8'h31 + 8'(i); exp_q.push_back(8'h31 + 8'(i));
    end
    @(negedge clk); valid_in = 1'b0;
    goto(c + 161);
    chk("t6_ready_full", ready_in, 0);
    chk("t6_count_full", fifo_count, 4);
    chk("t6_overflow_before", overflow, 0);
    valid_in = 1'b1; data_in = 8'hEE;
    @(negedge clk);
    valid_in = 1'b0;
    chk("t6_count_after", fifo_count, 3);
    chk("t6_overflow_after", overflow, 1);
    wait_frames(fd0 + 5, 5 * FRAME + 50);
    if (starts.size() >= 2) chk("t6_back_to_back", starts[1] - starts[0], FRAME);
    goto(c + 2 + 5 * FRAME);
    chk("t6_busy_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
